// File: rtl/slave_memory_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slave_memory_pkg : shared types and sizing helpers                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package slave_memory_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int calc_nbytes(input int data_size);
        return data_size / 8;
    endfunction

    function automatic int calc_nbeats(input int data_size, input int beat_bytes);
        return (data_size / 8) / beat_bytes;
    endfunction

    // One bit wider than any address so start+len wrap-around shows up as an error.
    function automatic logic range_error(input logic [64:0] start,
                                         input int          nbytes,
                                         input logic [64:0] last_addr);
        return (start + 65'(nbytes) - 65'd1) > last_addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slave_memory_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slave_memory_array : byte array, beat-wide write/async read port    |
// | Optional per-byte even parity with SLV_MEM_PARITY_EN. Rev 1.0       |
// +--------------------------------------------------------------------+
module slave_memory_array #(
    parameter int ADDR_SIZE  = 32,
    parameter int DEPTH      = 4096,
    parameter int BEAT_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_SIZE-1:0]    addr,
    input  logic [BEAT_BYTES*8-1:0] wdata,
    input  logic [BEAT_BYTES-1:0]   wstrb,
`ifdef SLV_MEM_PARITY_EN
    input  logic                    inject,
    output logic                    par_err,
`endif
    output logic [BEAT_BYTES*8-1:0] rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] idx [BEAT_BYTES];

    generate
        if (ADDR_SIZE > AW) begin : g_addr_hi
            // Upper address bits are range-checked upstream and never index the array.
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[ADDR_SIZE-1:AW];
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < BEAT_BYTES; i++) begin
            idx[i] = addr[AW-1:0] + AW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BEAT_BYTES; i++) begin
                if (wstrb[i]) begin
                    mem[idx[i]] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            rdata[i*8 +: 8] = mem[idx[i]];
        end
    end

`ifdef SLV_MEM_PARITY_EN
    logic par [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BEAT_BYTES; i++) begin
                if (wstrb[i]) begin
                    par[idx[i]] <= (^wdata[i*8 +: 8]) ^ inject;
                end
            end
        end
    end

    always_comb begin
        par_err = 1'b0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            par_err = par_err | (par[idx[i]] != (^mem[idx[i]]));
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/slave_memory_banked.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | slave_memory_banked : APB slave memory back end, BEAT_BYTES per clk |
// | Optional parity: SLV_MEM_PARITY_EN. Rev 1.0                         |
// +--------------------------------------------------------------------+
module slave_memory_banked
    import slave_memory_pkg::*;
#(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_SIZE  = 32,
    parameter int END_ADDR   = 4095,
    parameter int BEAT_BYTES = 1
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic [ADDR_SIZE-1:0]   PADDR,
    input  logic [DATA_SIZE-1:0]   PWDATA,
    input  logic [DATA_SIZE/8-1:0] PSTRB,
    output logic [DATA_SIZE-1:0]   PRDATA,
    input  logic                   write_init,
    input  logic                   read_init,
    output logic                   write_finished,
    output logic                   read_finished,
    output logic                   slverr,
    output logic                   busy
`ifdef SLV_MEM_PARITY_EN
    ,
    input  logic                   parity_inject
`endif
);
    localparam int NBYTES    = calc_nbytes(DATA_SIZE);
    localparam int NBEATS    = calc_nbeats(DATA_SIZE, BEAT_BYTES);
    localparam int BEAT_BITS = BEAT_BYTES * 8;
    localparam int CW        = $clog2(NBEATS) + 1;

    state_t                state;
    state_t                next_state;
    logic [ADDR_SIZE-1:0]  addr_q;
    logic [DATA_SIZE-1:0]  wdata_q;
    logic [DATA_SIZE-1:0]  shadow;
    logic [NBYTES-1:0]     strb_q;
    logic [CW-1:0]         cnt;
    logic                  is_read;
    logic                  range_err;
    logic                  par_err;
    logic                  accept;
    logic                  req_err;
    logic                  last_beat;
    logic                  mem_we;
    logic [BEAT_BITS-1:0]  beat_wdata;
    logic [BEAT_BITS-1:0]  beat_rdata;
    logic [BEAT_BYTES-1:0] beat_strb;
    logic                  beat_par_err;

    assign accept     = (state == IDLE) && (write_init || read_init);
    assign req_err    = range_error(65'(PADDR), NBYTES, 65'(END_ADDR));
    assign last_beat  = (cnt == CW'(NBEATS - 1));
    assign mem_we     = (state == WRITE);
    assign beat_wdata = wdata_q[int'(cnt) * BEAT_BITS +: BEAT_BITS];
    assign beat_strb  = strb_q[int'(cnt) * BEAT_BYTES +: BEAT_BYTES];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)         next_state = DONE;
                    else if (write_init) next_state = WRITE;
                    else                 next_state = READ;
                end
            end
            WRITE, READ: begin
                if (last_beat) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are registered off DONE, so they appear the cycle after it.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q         <= '0;
            wdata_q        <= '0;
            strb_q         <= '0;
            shadow         <= '0;
            cnt            <= '0;
            is_read        <= 1'b0;
            range_err      <= 1'b0;
            par_err        <= 1'b0;
            PRDATA         <= '0;
            write_finished <= 1'b0;
            read_finished  <= 1'b0;
            slverr         <= 1'b0;
            busy           <= 1'b0;
        end else begin
            if (accept) begin
                addr_q    <= PADDR;
                cnt       <= '0;
                is_read   <= ~write_init;
                range_err <= req_err;
                par_err   <= 1'b0;
                shadow    <= '0;
                if (write_init) begin
                    wdata_q <= PWDATA;
                    strb_q  <= PSTRB;
                end
            end
            if (state == WRITE || state == READ) begin
                addr_q <= addr_q + ADDR_SIZE'(BEAT_BYTES);
                cnt    <= cnt + CW'(1);
            end
            if (state == READ) begin
                shadow[int'(cnt) * BEAT_BITS +: BEAT_BITS] <= beat_rdata;
                par_err <= par_err | beat_par_err;
            end
            if (state == DONE && is_read) begin
                PRDATA <= range_err ? '0 : shadow;
            end
            write_finished <= (state == DONE) && !is_read;
            read_finished  <= (state == DONE) && is_read;
            slverr         <= (state == DONE) && (range_err || par_err);
            busy           <= (next_state != IDLE) || (state == DONE);
        end
    end

    slave_memory_array #(
        .ADDR_SIZE  (ADDR_SIZE),
        .DEPTH      (END_ADDR + 1),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_array (
        .clk     (PCLK),
        .we      (mem_we),
        .addr    (addr_q),
        .wdata   (beat_wdata),
        .wstrb   (beat_strb),
`ifdef SLV_MEM_PARITY_EN
        .inject  (parity_inject),
        .par_err (beat_par_err),
`endif
        .rdata   (beat_rdata)
    );

`ifndef SLV_MEM_PARITY_EN
    assign beat_par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slave_memory_banked.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_slave_memory_banked : scoreboard bench for two DUT configurations|
// | Parity scenario built with SLV_MEM_PARITY_EN. Rev 1.0               |
// +--------------------------------------------------------------------+
module tb_slave_memory_banked;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_strb;
    logic        a_wi, a_ri, a_wf, a_rf, a_err, a_busy;

    logic [31:0] b_addr;
    logic [63:0] b_wdata, b_rdata;
    logic [7:0]  b_strb;
    logic        b_wi, b_ri, b_wf, b_rf, b_err, b_busy;

`ifdef SLV_MEM_PARITY_EN
    logic a_inj, b_inj;
`endif

    slave_memory_banked #(.ADDR_SIZE(32), .DATA_SIZE(32), .END_ADDR(4095), .BEAT_BYTES(1)) dut_a (
        .PCLK(clk), .PRESETn(rst_n), .PADDR(a_addr), .PWDATA(a_wdata), .PSTRB(a_strb),
        .PRDATA(a_rdata), .write_init(a_wi), .read_init(a_ri), .write_finished(a_wf),
        .read_finished(a_rf), .slverr(a_err), .busy(a_busy)
`ifdef SLV_MEM_PARITY_EN
        , .parity_inject(a_inj)
`endif
    );

    slave_memory_banked #(.ADDR_SIZE(32), .DATA_SIZE(64), .END_ADDR(4095), .BEAT_BYTES(4)) dut_b (
        .PCLK(clk), .PRESETn(rst_n), .PADDR(b_addr), .PWDATA(b_wdata), .PSTRB(b_strb),
        .PRDATA(b_rdata), .write_init(b_wi), .read_init(b_ri), .write_finished(b_wf),
        .read_finished(b_rf), .slverr(b_err), .busy(b_busy)
`ifdef SLV_MEM_PARITY_EN
        , .parity_inject(b_inj)
`endif
    );

    typedef struct {
        bit          is_read;
        bit          err;
        logic [63:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  model [2][4096];
    bit          bad [4096];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic set_inj(input bit v);
`ifdef SLV_MEM_PARITY_EN
        a_inj = v;
`endif
    endtask

    task automatic sample(input bit big, output logic wf, output logic rf, output logic er,
                          output logic bz, output logic [63:0] rd);
        if (big) begin
            wf = b_wf; rf = b_rf; er = b_err; bz = b_busy; rd = b_rdata;
        end else begin
            wf = a_wf; rf = a_rf; er = a_err; bz = a_busy; rd = {32'd0, a_rdata};
        end
    endtask

    // Drives one request, pushes the model's expectation, then waits for and scores the pulse.
    task automatic xfer(input string name, input bit big, input bit wr, input bit both,
                        input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                        input bit inject, input bit poke);
        exp_t        e, got;
        int          nbytes, nbeats;
        logic [11:0] ba;
        logic        wf, rf, er, bz;
        logic [63:0] rd;
        bit          seen;
        nbytes    = big ? 8 : 4;
        nbeats    = big ? 2 : 4;
        e.is_read = !wr;
        e.err     = ({32'd0, addr} + 64'(nbytes) - 64'd1) > 64'd4095;
        e.lat     = e.err ? 1 : nbeats + 1;
        e.data    = '0;
        if (!e.err) begin
            for (int k = 0; k < nbytes; k++) begin
                ba = 12'(addr + 32'(k));
                if (wr) begin
                    if (strb[k]) begin
                        model[int'(big)][ba] = data[k*8 +: 8];
                        if (!big) bad[ba] = inject && (k == 2);
                    end
                end else begin
                    e.data[k*8 +: 8] = model[int'(big)][ba];
                    if (!big && bad[ba]) e.err = 1'b1;
                end
            end
        end
        sb.push_back(e);

        @(negedge clk);
        if (big) begin
            b_addr = addr; b_wdata = data; b_strb = strb;
            b_wi = wr || both; b_ri = !wr || both;
        end else begin
            a_addr = addr; a_wdata = data[31:0]; a_strb = strb[3:0];
            a_wi = wr || both; a_ri = !wr || both;
        end
        @(posedge clk); #1;
        a_wi = 1'b0; a_ri = 1'b0; b_wi = 1'b0; b_ri = 1'b0;

        seen = 1'b0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            if (k == 3) set_inj(inject);
            if (k == 4) set_inj(1'b0);
            if (poke && k == 2) begin a_ri = 1'b1; a_addr = 32'h100; end
            if (poke && k == 3) a_ri = 1'b0;
            @(posedge clk); #1;
            sample(big, wf, rf, er, bz, rd);
            if (k == 1) begin
                n_tests++;
                if (bz !== 1'b1) begin
                    n_fail++; $display("FAIL %s busy_after_accept: got %b expected 1", name, bz);
                end
            end
            if (wf === 1'b1 || rf === 1'b1) begin
                seen = 1'b1;
                got  = sb.pop_front();
                n_tests++;
                if (k != got.lat) begin
                    n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, k, got.lat);
                end
                n_tests++;
                if (wf !== !got.is_read || rf !== got.is_read) begin
                    n_fail++; $display("FAIL %s pulse_kind: got wf=%b rf=%b expected read=%b", name, wf, rf, got.is_read);
                end
                n_tests++;
                if (er !== got.err) begin
                    n_fail++; $display("FAIL %s slverr: got %b expected %b", name, er, got.err);
                end
                if (got.is_read) begin
                    n_tests++;
                    if (rd !== got.data) begin
                        n_fail++; $display("FAIL %s prdata: got %h expected %h", name, rd, got.data);
                    end
                end
                n_tests++;
                if (bz !== 1'b1) begin
                    n_fail++; $display("FAIL %s busy_with_pulse: got %b expected 1", name, bz);
                end
            end
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout: got no finished pulse expected one within 12 cycles", name);
            got = sb.pop_front();
        end
        @(posedge clk); #1;
        sample(big, wf, rf, er, bz, rd);
        n_tests++;
        if (wf !== 1'b0 || rf !== 1'b0 || bz !== 1'b0) begin
            n_fail++; $display("FAIL %s after_pulse: got wf=%b rf=%b busy=%b expected 0 0 0", name, wf, rf, bz);
        end
    endtask

    task automatic test_quiet(input string name, input int cycles);
        bit any = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (a_wf !== 1'b0 || a_rf !== 1'b0 || b_wf !== 1'b0 || b_rf !== 1'b0) any = 1'b1;
        end
        n_tests++;
        if (any) begin
            n_fail++; $display("FAIL %s stray_pulse: got a pulse expected none", name);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_wi = 1'b0; a_ri = 1'b0; a_addr = '0; a_wdata = '0; a_strb = '0;
        b_wi = 1'b0; b_ri = 1'b0; b_addr = '0; b_wdata = '0; b_strb = '0;
        set_inj(1'b0);
`ifdef SLV_MEM_PARITY_EN
        b_inj = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({a_rdata, a_wf, a_rf, a_err, a_busy} !== 36'd0) begin
            n_fail++; $display("FAIL reset_a: got %h expected 0", {a_rdata, a_wf, a_rf, a_err, a_busy});
        end
        n_tests++;
        if ({b_rdata, b_wf, b_rf, b_err, b_busy} !== 68'd0) begin
            n_fail++; $display("FAIL reset_b: got %h expected 0", {b_rdata, b_wf, b_rf, b_err, b_busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        xfer("wr_deadbeef", 0, 1, 0, 32'h10, 64'hDEADBEEF, 8'hF, 0, 0);
        xfer("rd_deadbeef", 0, 0, 0, 32'h10, 64'h0, 8'h0, 0, 0);
    endtask

    task automatic test_partial_strobe;
        xfer("wr_prior",   0, 1, 0, 32'h20, 64'hAAAAAAAA, 8'hF, 0, 0);
        xfer("wr_partial", 0, 1, 0, 32'h20, 64'h11223344, 8'h5, 0, 0);
        xfer("rd_partial", 0, 0, 0, 32'h20, 64'h0, 8'h0, 0, 0);
    endtask

    task automatic test_wide_unaligned;
        xfer("wide_wr", 1, 1, 0, 32'h7, 64'h0123456789ABCDEF, 8'hFF, 0, 0);
        xfer("wide_rd", 1, 0, 0, 32'h7, 64'h0, 8'h0, 0, 0);
        xfer("wide_rd_err", 1, 0, 0, 32'd4090, 64'h0, 8'h0, 0, 0);
    endtask

    task automatic test_range_error;
        xfer("rd_edge_err", 0, 0, 0, 32'd4094, 64'h0, 8'h0, 0, 0);
        xfer("wr_top_ok",   0, 1, 0, 32'hFFC, 64'h55667788, 8'hF, 0, 0);
        xfer("wr_wrap_err", 0, 1, 0, 32'hFFFFFFFE, 64'hFFFFFFFF, 8'hF, 0, 0);
        xfer("rd_top_keep", 0, 0, 0, 32'hFFC, 64'h0, 8'h0, 0, 0);
    endtask

    task automatic test_collision;
        xfer("both_init", 0, 1, 1, 32'h30, 64'hA5A55A5A, 8'hF, 0, 0);
        test_quiet("both_init_quiet", 8);
        xfer("rd_collision", 0, 0, 0, 32'h30, 64'h0, 8'h0, 0, 0);
    endtask

    task automatic test_busy_ignore;
        xfer("busy_poke", 0, 1, 0, 32'h50, 64'h0BADF00D, 8'hF, 0, 1);
        test_quiet("busy_poke_quiet", 8);
    endtask

    task automatic test_reset_mid_write;
        logic wf, rf, er, bz;
        logic [63:0] rd;
        xfer("pre_clear", 0, 1, 0, 32'h40, 64'h0, 8'hF, 0, 0);
        @(negedge clk);
        a_addr = 32'h40; a_wdata = 32'h12345678; a_strb = 4'hF; a_wi = 1'b1;
        @(posedge clk); #1;
        a_wi = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        sample(0, wf, rf, er, bz, rd);
        n_tests++;
        if (bz !== 1'b0 || wf !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got busy=%b wf=%b expected 0 0", bz, wf);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model[0][12'h40] = 8'h78;
        model[0][12'h41] = 8'h56;
        test_quiet("mid_reset_quiet", 8);
        xfer("rst_readback", 0, 0, 0, 32'h40, 64'h0, 8'h0, 0, 0);
    endtask

`ifdef SLV_MEM_PARITY_EN
    task automatic test_parity;
        xfer("par_wr_inject", 0, 1, 0, 32'h60, 64'hCAFEBABE, 8'hF, 1, 0);
        xfer("par_rd_bad",    0, 0, 0, 32'h60, 64'h0, 8'h0, 0, 0);
        xfer("par_wr_clean",  0, 1, 0, 32'h60, 64'hCAFEBABE, 8'hF, 0, 0);
        xfer("par_rd_good",   0, 0, 0, 32'h60, 64'h0, 8'h0, 0, 0);
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_wide_unaligned();
        test_range_error();
        test_collision();
        test_busy_ignore();
        test_reset_mid_write();
`ifdef SLV_MEM_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
